// File: rtl/rib_xbar_arb.sv
// rib_xbar_arb: N-master / M-slave shared-bus arbiter and address decoder.
//   A single transaction is in flight at a time. The grant is registered in IDLE.
//   In BUSY the granted master is routed to the slave named by the top address
//   bits until that slave acks or the timeout expires. Addresses that decode
//   beyond NUM_S get an error response without touching any slave.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_addr_i/m_data_i packed master address/write data, master k at [k*W +: W]
//   m_we_i/m_req_i    master write enable / request (held until m_ack_o)
//   m_data_o          read data, only in the granted master's slot with its ack
//   m_ack_o/m_err_o   one-cycle completion pulse / error qualifier
//   s_addr_o/s_data_o address (select bits cleared) / write data to slaves
//   s_we_o/s_req_o    one-hot write enable / request to the selected slave
//   s_data_i/s_ack_i  packed slave read data / slave acks
//   hold_flag_o       a HOLD_MASK master owns, or is requesting, the bus
// Configuration macro: RIB_RR_ARB_EN selects round-robin arbitration instead of
//   fixed priority (lowest master index wins).
module rib_xbar_arb #(
  parameter int              NUM_M     = 4,
  parameter int              NUM_S     = 8,
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              SEL_BITS  = 4,
  parameter int              TIMEOUT   = 255,
  parameter logic [NUM_M-1:0] HOLD_MASK = NUM_M'(4'b1101)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_data_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M-1:0]    m_req_i,
  output logic [NUM_M*DW-1:0] m_data_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_data_o,
  output logic [NUM_S-1:0]    s_we_o,
  output logic [NUM_S-1:0]    s_req_o,
  input  logic [NUM_S*DW-1:0] s_data_i,
  input  logic [NUM_S-1:0]    s_ack_i,
  output logic                hold_flag_o
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [AW-1:0] ADDR_MASK = {{SEL_BITS{1'b0}}, {(AW-SEL_BITS){1'b1}}};

  // Decode errors take two states so the error ack lands one cycle after entry.
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DECERR, ST_DERR_RSP} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                any_req;
  logic [GW-1:0]       win;
  logic [AW-1:0]       win_addr;
  logic [SEL_BITS-1:0] win_sel;
  logic                done;
  logic                ack;
  logic                err;
  logic [DW-1:0]       rdata;
  logic [AW-1:0]       g_addr;
  logic [DW-1:0]       g_data;
  logic                g_we;
  logic                g_hold;
  logic                sel_ack;
  logic [DW-1:0]       sel_rdata;

  assign any_req = |m_req_i;

`ifdef RIB_RR_ARB_EN
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;

  // Pick the requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    int unsigned best;
    int unsigned dist;
    logic        found;
    win   = '0;
    best  = 0;
    dist  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      dist = (k + NUM_M - int'(rr_ptr_q)) % NUM_M;
      if (m_req_i[k] && (!found || dist < best)) begin
        found = 1'b1;
        best  = dist;
        win   = GW'(k);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (done) rr_ptr_d = (int'(gnt_q) == NUM_M - 1) ? '0 : gnt_q + GW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (!found && m_req_i[k]) begin
        found = 1'b1;
        win   = GW'(k);
      end
    end
  end
`endif

  // Master and slave muxes are written as compare loops so every index stays constant.
  always_comb begin
    win_addr = '0;
    g_addr   = '0;
    g_data   = '0;
    g_we     = 1'b0;
    g_hold   = 1'b0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (win == GW'(k)) win_addr = m_addr_i[k*AW +: AW];
      if (gnt_q == GW'(k)) begin
        g_addr = m_addr_i[k*AW +: AW];
        g_data = m_data_i[k*DW +: DW];
        g_we   = m_we_i[k];
        g_hold = HOLD_MASK[k];
      end
    end
    win_sel = win_addr[AW-1 -: SEL_BITS];
  end

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      if (sel_q == SEL_BITS'(s)) begin
        sel_ack   = s_ack_i[s];
        sel_rdata = s_data_i[s*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    ack      = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = '0;
    s_req_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          sel_d   = win_sel;
          cnt_d   = '0;
          state_d = (int'(win_sel) >= NUM_S) ? ST_DECERR : ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_addr_o = g_addr & ADDR_MASK;
        s_data_o = g_data;
        for (int unsigned s = 0; s < NUM_S; s++) begin
          if (sel_q == SEL_BITS'(s)) begin
            s_req_o[s] = 1'b1;
            s_we_o[s]  = g_we;
          end
        end
        // An ack in the final timeout cycle still completes without error.
        if (sel_ack) begin
          done  = 1'b1;
          ack   = 1'b1;
          rdata = sel_rdata;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          done = 1'b1;
          ack  = 1'b1;
          err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) state_d = ST_IDLE;
      end
      ST_DECERR: state_d = ST_DERR_RSP;
      ST_DERR_RSP: begin
        done    = 1'b1;
        ack     = 1'b1;
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A transaction caught by reset is abandoned: its ack is suppressed.
  always_comb begin
    m_ack_o  = '0;
    m_err_o  = '0;
    m_data_o = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (gnt_q == GW'(k) && ack && !rst) begin
        m_ack_o[k]           = 1'b1;
        m_err_o[k]           = err;
        m_data_o[k*DW +: DW] = rdata;
      end
    end
  end

  assign hold_flag_o = (state_q == ST_IDLE) ? |(m_req_i & HOLD_MASK) : g_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
